// File: rtl/conv_macc_seq.sv
// Sequential signed multiply-accumulate over TAPS beats, seeded with a bias, with a
// saturated valid/ready result. Define MACC_RELU_EN to apply ReLU ahead of saturation.
module conv_macc_seq #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int TAPS     = 3,
    parameter int OUT_W    = 16,
    parameter int ACC_W    = DATA_W + WEIGHT_W + $clog2(TAPS) + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic signed [OUT_W-1:0]    bias,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic signed [WEIGHT_W-1:0] in_weight,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       out_sat,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam int CMP_W  = ACC_W + OUT_W;
    localparam logic signed [CMP_W-1:0] SAT_MAX = CMP_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [CMP_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic signed [ACC_W-1:0]   acc, acc_n;
    logic signed [OUT_W-1:0]   out_data_n;
    logic                      out_sat_n, out_valid_n;
    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   prod_ext, bias_ext;
    logic                      accept;

    assign product  = in_data * in_weight;
    assign prod_ext = ACC_W'(product);
    assign bias_ext = ACC_W'(bias);
    assign in_ready = (state != OUT);
    assign accept   = in_valid && in_ready;

    // Comparison runs in a width that holds both acc and the OUT_W limits.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [CMP_W-1:0] w;
        w = CMP_W'(a);
`ifdef MACC_RELU_EN
        if (a < 0) return '0;
`endif
        if (w > SAT_MAX)      return {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (w < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
        else                  return {1'b0, OUT_W'(a)};
    endfunction

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        acc_n       = acc;
        out_data_n  = out_data;
        out_sat_n   = out_sat;
        out_valid_n = out_valid;
        if (clear) begin
            state_n     = IDLE;
            cnt_n       = '0;
            acc_n       = '0;
            out_valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc_n   = bias_ext + prod_ext;
                    cnt_n   = CNT_W'(1);
                    state_n = (TAPS == 1) ? OUT : ACCUM;
                end
                ACCUM: if (accept) begin
                    acc_n   = acc + prod_ext;
                    cnt_n   = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(TAPS - 1)) state_n = OUT;
                end
                OUT: if (out_ready) begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    acc_n       = '0;
                    out_valid_n = 1'b0;
                end
                default: state_n = IDLE;
            endcase
            // Result is registered on the same edge that accepts the final beat.
            if (state != OUT && state_n == OUT) begin
                out_valid_n             = 1'b1;
                {out_sat_n, out_data_n} = saturate(acc_n);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            out_data  <= out_data_n;
            out_sat   <= out_sat_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_conv_macc_seq.sv
// Directed bench for conv_macc_seq: vector table of full windows plus sequences for
// backpressure, bubbles, clear, and asynchronous reset. Honours MACC_RELU_EN expectations.
module tb_conv_macc_seq;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clear = 1'b0;
    logic signed [15:0] bias = '0;
    logic signed [7:0]  in_data = '0;
    logic signed [7:0]  in_weight = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_sat;
    logic               out_valid;
    logic               out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int accepted = 0;

    conv_macc_seq #(
        .DATA_W(8), .WEIGHT_W(8), .TAPS(3), .OUT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bias(bias),
        .in_data(in_data), .in_weight(in_weight), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && !clear && in_valid && in_ready) accepted++;

    typedef struct {
        string name;
        int    b;
        int    d0, w0, d1, w1, d2, w2;
        int    exp_data;
        int    exp_sat;
    } vec_t;

    vec_t vecs[9];

    function automatic int exp_d(input int d);
`ifdef MACC_RELU_EN
        return (d < 0) ? 0 : d;
`else
        return d;
`endif
    endfunction

    function automatic int exp_s(input int d, input int s);
`ifdef MACC_RELU_EN
        return (d < 0) ? 0 : s;
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int b, input int d, input int w, input logic v);
        bias      = 16'(b);
        in_data   = 8'(d);
        in_weight = 8'(w);
        in_valid  = v;
        tick();
    endtask

    task automatic handshake(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_in_ready_back"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    task automatic expect_result(input string name, input int d, input int s);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, exp_d(d));
        check({name, "_sat"}, out_sat, exp_s(d, s));
        check({name, "_in_ready_low"}, in_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int a0;
        vecs[0] = '{"basic",      10,     2, 3, -4, 5, 7, -1,     -11,    0};
        vecs[1] = '{"pos_sat",    0,      127, 127, 127, 127, 127, 127, 32767, 1};
        vecs[2] = '{"neg_sat",    0,      -128, 127, -128, 127, -128, 127, -32768, 1};
        vecs[3] = '{"neg_prod",   -32768, -128, -128, -128, -128, -128, -128, 16384, 0};
        vecs[4] = '{"max_edge",   32767,  0, 0, 0, 0, 0, 0,       32767,  0};
        vecs[5] = '{"max_plus1",  32767,  1, 1, 0, 0, 0, 0,       32767,  1};
        vecs[6] = '{"min_edge",   -32768, 5, 0, 0, -7, 0, 0,      -32768, 0};
        vecs[7] = '{"min_minus1", -32768, -1, 1, 0, 0, 0, 0,      -32768, 1};
        vecs[8] = '{"zero",       0,      0, 0, 0, 0, 0, 0,       0,      0};

        // Reset state
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Table-driven full windows; bias on beats 2..3 is garbage and must be ignored
        for (int i = 0; i < 9; i++) begin
            beat(vecs[i].b, vecs[i].d0, vecs[i].w0, 1'b1);
            beat(16'h1234, vecs[i].d1, vecs[i].w1, 1'b1);
            check({vecs[i].name, "_no_early_valid"}, out_valid, 0);
            beat(-999, vecs[i].d2, vecs[i].w2, 1'b1);
            expect_result(vecs[i].name, vecs[i].exp_data, vecs[i].exp_sat);
            handshake(vecs[i].name);
        end

        // Backpressure: result held, input beats refused
        beat(10, 2, 3, 1'b1);
        beat(0, -4, 5, 1'b1);
        beat(0, 7, -1, 1'b1);
        a0 = accepted;
        for (int c = 0; c < 5; c++) begin
            beat(100, 9, 9, 1'b1);
            expect_result("bp_hold", -11, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_valid_drop", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_no_accept", accepted - a0, 0);

        // Bubbles in in_valid: 1,0,0,1,0,1
        a0 = accepted;
        beat(10, 2, 3, 1'b1);
        beat(555, 99, 99, 1'b0);
        beat(555, 99, 99, 1'b0);
        beat(777, -4, 5, 1'b1);
        beat(777, 50, 50, 1'b0);
        check("bub_no_early_valid", out_valid, 0);
        beat(777, 7, -1, 1'b1);
        expect_result("bub", -11, 0);
        check("bub_accept_count", accepted - a0, 3);
        handshake("bub");

        // clear after two beats, coincident beat dropped
        beat(50, 10, 10, 1'b1);
        beat(50, 10, 10, 1'b1);
        clear = 1'b1;
        beat(50, 10, 10, 1'b1);
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 1);
        beat(1, 1, 1, 1'b1);
        beat(1, 1, 1, 1'b1);
        beat(1, 1, 1, 1'b1);
        expect_result("clr_fresh", 4, 0);

        // clear during OUT wins over the handshake; out_data retained
        out_ready = 1'b1;
        clear     = 1'b1;
        beat(0, 0, 0, 1'b0);
        clear     = 1'b0;
        out_ready = 1'b0;
        check("clr_out_valid", out_valid, 0);
        check("clr_out_data_kept", out_data, 4);
        check("clr_out_in_ready", in_ready, 1);

        // clear coincident with the final beat
        beat(1, 1, 1, 1'b1);
        beat(1, 1, 1, 1'b1);
        clear = 1'b1;
        beat(1, 1, 1, 1'b1);
        clear = 1'b0;
        check("clr_final_valid", out_valid, 0);
        beat(0, 0, 0, 1'b0);
        check("clr_final_still_idle", out_valid, 0);
        beat(3, 2, 2, 1'b1);
        beat(3, 0, 0, 1'b1);
        beat(3, 0, 0, 1'b1);
        expect_result("clr_after_final", 7, 0);
        handshake("clr_after_final");

        // Asynchronous reset mid-ACCUM, between clock edges
        beat(100, 5, 5, 1'b1);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_sat", out_sat, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_release_in_ready", in_ready, 1);
        beat(10, 2, 3, 1'b1);
        beat(0, -4, 5, 1'b1);
        beat(0, 7, -1, 1'b1);
        expect_result("arst_next", -11, 0);
        handshake("arst_next");

        // Asynchronous reset while holding a saturated result
        beat(0, 127, 127, 1'b1);
        beat(0, 127, 127, 1'b1);
        beat(0, 127, 127, 1'b1);
        expect_result("arst_out_pre", 32767, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_sat", out_sat, 0);
        check("arst_out_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_macc_seq.md
Name: conv_macc_seq

Overview:
- Sequential, parametrised multiply-accumulate engine for the CNN convolution layers.
- Consumes one (input, weight) pair per accepted beat over a window of TAPS beats, seeded with a bias.
- Emits one saturated, signed result per window through a valid/ready output.
- Replaces chained single-shot combinational multiply-add cells in the conv datapath.

Parameters:
- DATA_W, 8, signed input sample width
- WEIGHT_W, 8, signed weight width
- TAPS, 3, products accumulated per window (>=1)
- OUT_W, 16, signed result and bias width
- ACC_W, DATA_W+WEIGHT_W+$clog2(TAPS)+2, internal accumulator width; sized so it never overflows

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort of the current window
- bias  in  OUT_W  signed bias; sampled on the first accepted beat of a window
- in_data  in  DATA_W  signed sample
- in_weight  in  WEIGHT_W  signed weight
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept a beat
- out_data  out  OUT_W  signed saturated result
- out_sat  out  1  result was clipped
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: state=IDLE, tap counter=0, acc=0, out_data=0, out_sat=0, out_valid=0.
- in_ready decodes from state: 1 in IDLE/ACCUM, 0 in OUT. It reads 1 immediately after reset.
- A beat is accepted when in_valid && in_ready at a clk edge.
- Arithmetic: product = in_data*in_weight, full DATA_W+WEIGHT_W signed, sign-extended to ACC_W. Bias is sign-extended to ACC_W.
- IDLE: accepted beat -> acc = bias + product, cnt = 1. Next state is ACCUM, or OUT if TAPS==1.
- ACCUM: accepted beat -> acc += product, cnt++. When the beat is number TAPS, go to OUT.
- ACCUM with in_valid low: hold. No timeout.
- Entry to OUT: out_valid=1 the cycle after the final beat, so latency from final beat to out_valid is 1 cycle. On the same edge, out_data/out_sat are registered from acc saturated to OUT_W:
  - acc > 2^(OUT_W-1)-1 -> max, out_sat=1
  - acc < -2^(OUT_W-1) -> min, out_sat=1
  - otherwise out_sat=0
- OUT: out_data, out_sat and out_valid stay stable until out_valid && out_ready.
- On that handshake: out_valid=0, state=IDLE, cnt=0, acc=0. in_ready rises the next cycle.
- Minimum window period: TAPS+1 cycles.
- clear has priority over everything, including the final beat and the output handshake. Next edge: state=IDLE, cnt=0, acc=0, out_valid=0. out_data keeps its last value. The coincident input beat is dropped.
- rst_n asserted mid-window or mid-OUT: immediate return to reset state. The partial window is lost.
- in_data/in_weight/bias are ignored when not accepted. bias is ignored on beats 2..TAPS.

Optional Feature:
- Macro: MACC_RELU_EN
- Defined: ReLU is applied before saturation. acc < 0 gives out_data=0 and out_sat=0; positive overflow still saturates with out_sat=1.
- Undefined: signed result passes through saturation only. No other differences; identical handshake and latency.

Test Plan:
- Basic window, TAPS=3, OUT_W=16: bias=10, beats (2,3),(-4,5),(7,-1) back-to-back -> out_valid one cycle after 3rd beat, out_data=-11 (0 with MACC_RELU_EN), out_sat=0.
- Positive saturation: bias=0, three beats (127,127) -> acc=48387, out_data=32767, out_sat=1. Negative: three beats (-128,127) -> acc=-48768, out_data=-32768, out_sat=1 (0/0 with MACC_RELU_EN).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data/out_valid stable, in_ready=0, in_valid beats not accepted. out_ready=1 -> out_valid drops, in_ready=1 next cycle.
- Bubbles: in_valid toggled 1,0,0,1,0,1 with the basic-window data -> same result -11; accepted-beat count exactly 3.
- clear after 2 accepted beats, then full window bias=1, (1,1)x3 -> out_data=4, no stale contribution. clear during OUT with out_ready=1 -> no handshake counted, out_valid=0.
- Async rst_n low mid-ACCUM (between clock edges) -> all outputs at reset values immediately, in_ready=1 after release. Subsequent window is correct.
